psum_acc_buffer: RTL and testbench
==================================

Name: psum_acc_buffer

Overview:
- Downstream neighbour of the PE engine. Consumes the Tout per-pixel partial sums the PE array produces for each input-channel tile, and accumulates them in an on-chip psum RAM indexed by (row, col).
- On the last input-channel tile it adds the bias, shifts, rounds, optionally applies ReLU and saturates, then emits one quantised Tout-lane output word per pixel to the OFM writer.

Parameters:
- Tout, 4, number of output-channel lanes per word.
- W_PSUM, 32, signed width of each psum lane.
- W_SIZE, 9, row/col/width field width.
- BUF_AW, 16, psum RAM address width; depth is 2^BUF_AW words of Tout*W_PSUM bits.
- OUT_DW, 8, signed width of each output lane.
- W_SHIFT, 5, width of the requantisation shift amount.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, reset: synchronous, active-low.
- i_width, input, W_SIZE, frame width in pixels; stable for the whole frame.
- i_shift, input, W_SHIFT, arithmetic right shift applied on the last tile; stable for the whole frame.
- i_relu, input, 1, ReLU enable; stable for the whole frame.
- i_bias_flat, input, Tout*W_PSUM, signed bias, lane g at [(g+1)*W_PSUM-1 -: W_PSUM]; stable for the whole frame.
- i_vld, input, 1, partial-sum word valid.
- i_acc_flat, input, Tout*W_PSUM, signed partial sums, same lane packing as i_bias_flat.
- i_row, input, W_SIZE, pixel row of this word.
- i_col, input, W_SIZE, pixel column of this word.
- i_first_tile, input, 1, first input-channel tile: stored value ignored and treated as 0.
- i_last_tile, input, 1, last input-channel tile: post-process and emit instead of write-back.
- o_vld, output, 1, output word valid.
- o_data_flat, output, Tout*OUT_DW, quantised lanes.
- o_row, output, W_SIZE, row of the output word.
- o_col, output, W_SIZE, column of the output word.

Behaviour:
- Reset: o_vld, o_data_flat, o_row, o_col and all pipeline valids go to 0 on the first rising edge with rstn=0. RAM contents are not reset.
- Throughput: one word per cycle, no back-pressure, i_vld may be high every cycle.
- Address: addr = i_row*i_width + i_col, truncated to BUF_AW bits.
- S1, cycle t: register inputs and addr; issue a synchronous RAM read.
- S2, cycle t+1:
  - operand = 0 if first_tile; else the forwarded value if the hazard rule below fires; else the RAM read data.
  - sum[g] = operand[g] + acc[g], wrapping two's complement in W_PSUM bits.
  - If not last_tile: write sum to RAM at addr on the edge ending t+1.
  - If last_tile: no write; sum passes to S3.
- Hazard: the S1 read and the S2 write share an edge, and read-during-write returns old data.
  - When the S2 word is valid and not last_tile, the S1 word is valid, and both addresses are equal, the S1 word takes its operand from S2's sum (one-deep forward).
  - Words two or more cycles apart need no forwarding.
- S3, cycle t+2:
  - v = sum + bias[g], wrap in W_PSUM.
  - If i_shift > 0: r = (v + 2^(i_shift-1)) >>> i_shift, rounding half toward +inf. If i_shift = 0: r = v.
  - If i_relu and r < 0: r = 0.
  - Saturate r to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1].
  - Register the result. o_vld = 1 in cycle t+3 for exactly one cycle, with o_row/o_col from the same word.
- first_tile and last_tile both set (single tile): result = acc + bias, RAM untouched.
- When o_vld = 0: o_data_flat, o_row and o_col hold their last values.
- rstn low mid-operation: all in-flight words are discarded, no o_vld until new input arrives, RAM writes in the reset cycle are suppressed.
- Out-of-range row/col: address wraps silently; no error flag.

Decomposition:
- Shared package / controller_params.vh: Tout, W_PSUM, OUT_DW, W_SHIFT, BUF_AW, lane pack/unpack width constants.
- Sub-module psum_postproc: one lane of bias add, round-shift, ReLU and saturate; combinational; instantiated Tout times inside S3.
- RAM: inferred simple dual-port, synchronous read, inside the top module.

Test Plan:
1. Single tile: first=last=1, acc={10,-20,300,5}, bias 0, shift 0, relu 0 -> o_data={10,-20,127,5} three cycles later, RAM unchanged.
2. Three tiles at row 1, col 2, width 16 (addr 18), non-adjacent cycles, lane0 acc 100 each, bias 6, shift 2 -> lane0 = (306+2)>>>2 = 77, o_row=1, o_col=2.
3. Forwarding: back-to-back cycles, same addr, first tile acc 7 then last tile acc 8, bias 0, shift 0 -> output 15. Repeat with words at distance 2 -> 15.
4. ReLU/saturation: last tile value -50 with relu=1 -> 0; value -300 with relu=0 -> -128; value 1000, shift 3 -> 125.
5. Reset: assert rstn=0 for one cycle right after an i_vld last-tile word -> o_vld never asserts for it, outputs read 0. Next word processed normally.
6. Streaming: 48 consecutive words, 16x3 frame, two tiles -> 48 o_vld pulses in raster order, each 3 cycles after its last-tile input.

Source files
------------

// File: rtl/psum_acc_buffer_pkg.sv
// Shared constants and types for the partial-sum accumulation buffer.
package psum_acc_buffer_pkg;

  localparam int unsigned DEF_TOUT    = 4;
  localparam int unsigned DEF_W_PSUM  = 32;
  localparam int unsigned DEF_W_SIZE  = 9;
  localparam int unsigned DEF_BUF_AW  = 16;
  localparam int unsigned DEF_OUT_DW  = 8;
  localparam int unsigned DEF_W_SHIFT = 5;

  localparam int unsigned DEF_ACC_FLAT_W = DEF_TOUT * DEF_W_PSUM;
  localparam int unsigned DEF_OUT_FLAT_W = DEF_TOUT * DEF_OUT_DW;

  typedef enum logic [1:0] {
    OPND_ZERO,
    OPND_FWD,
    OPND_RAM
  } opnd_sel_e;

endpackage

// File: rtl/psum_acc_buffer_postproc.sv
// One output lane: bias add, round-half-up arithmetic shift, optional ReLU, saturate.
module psum_postproc
  import psum_acc_buffer_pkg::*;
#(
  parameter int unsigned W_PSUM  = DEF_W_PSUM,
  parameter int unsigned OUT_DW  = DEF_OUT_DW,
  parameter int unsigned W_SHIFT = DEF_W_SHIFT
) (
  input  logic signed [W_PSUM-1:0]  sum,
  input  logic signed [W_PSUM-1:0]  bias,
  input  logic        [W_SHIFT-1:0] shift,
  input  logic                      relu,
  output logic signed [OUT_DW-1:0]  q
);

  localparam logic signed [W_PSUM:0] SAT_MAX = (W_PSUM+1)'((1 << (OUT_DW-1)) - 1);
  localparam logic signed [W_PSUM:0] SAT_MIN = (W_PSUM+1)'(-(1 << (OUT_DW-1)));

  logic signed [W_PSUM-1:0] v;
  logic signed [W_PSUM:0]   rnd;
  logic signed [W_PSUM:0]   vr;
  logic signed [W_PSUM:0]   r;

  // One guard bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    v   = sum + bias;
    rnd = '0;
    if (shift != '0) rnd = (W_PSUM+1)'(1) << (shift - 1'b1);
    vr  = {v[W_PSUM-1], v} + rnd;
    r   = vr >>> shift;
    if (relu && r[W_PSUM]) r = '0;
    if (r > SAT_MAX)      q = SAT_MAX[OUT_DW-1:0];
    else if (r < SAT_MIN) q = SAT_MIN[OUT_DW-1:0];
    else                  q = r[OUT_DW-1:0];
  end

endmodule

// File: rtl/psum_acc_buffer.sv
// Accumulates per-pixel partial sums across input-channel tiles in a psum RAM and
// emits requantised output words on the last tile.
module psum_acc_buffer
  import psum_acc_buffer_pkg::*;
#(
  parameter int unsigned Tout    = DEF_TOUT,
  parameter int unsigned W_PSUM  = DEF_W_PSUM,
  parameter int unsigned W_SIZE  = DEF_W_SIZE,
  parameter int unsigned BUF_AW  = DEF_BUF_AW,
  parameter int unsigned OUT_DW  = DEF_OUT_DW,
  parameter int unsigned W_SHIFT = DEF_W_SHIFT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [W_SIZE-1:0]        i_width,
  input  logic [W_SHIFT-1:0]       i_shift,
  input  logic                     i_relu,
  input  logic [Tout*W_PSUM-1:0]   i_bias_flat,
  input  logic                     i_vld,
  input  logic [Tout*W_PSUM-1:0]   i_acc_flat,
  input  logic [W_SIZE-1:0]        i_row,
  input  logic [W_SIZE-1:0]        i_col,
  input  logic                     i_first_tile,
  input  logic                     i_last_tile,
  output logic                     o_vld,
  output logic [Tout*OUT_DW-1:0]   o_data_flat,
  output logic [W_SIZE-1:0]        o_row,
  output logic [W_SIZE-1:0]        o_col
);

  localparam int unsigned ACC_W = Tout * W_PSUM;
  localparam int unsigned OUT_W = Tout * OUT_DW;
  localparam int unsigned MUL_W = 2 * W_SIZE + 1;

  logic [ACC_W-1:0] ram [0:(1<<BUF_AW)-1];
  logic [ACC_W-1:0] rd_data;

  logic [BUF_AW-1:0] addr_in;

  logic              s1_vld, s1_first, s1_last, s1_fwd;
  logic [ACC_W-1:0]  s1_acc, s1_fwd_data;
  logic [W_SIZE-1:0] s1_row, s1_col;
  logic [BUF_AW-1:0] s1_addr;

  logic              s2_vld;
  logic [ACC_W-1:0]  s2_sum;
  logic [W_SIZE-1:0] s2_row, s2_col;

  opnd_sel_e        opnd_sel;
  logic [ACC_W-1:0] operand, sum;
  logic             wr_en, fwd_hit;
  logic [OUT_W-1:0] q_flat;

  assign addr_in = BUF_AW'(MUL_W'(i_row) * MUL_W'(i_width) + MUL_W'(i_col));
  assign wr_en   = s1_vld && !s1_last;
  // The RAM returns old data when read and written on the same edge, so the
  // word being read now takes the sum that is about to be written instead.
  assign fwd_hit = wr_en && i_vld && (addr_in == s1_addr);

  always_comb begin
    if (s1_first)    opnd_sel = OPND_ZERO;
    else if (s1_fwd) opnd_sel = OPND_FWD;
    else             opnd_sel = OPND_RAM;
    case (opnd_sel)
      OPND_ZERO: operand = '0;
      OPND_FWD:  operand = s1_fwd_data;
      default:   operand = rd_data;
    endcase
    sum = '0;
    for (int unsigned g = 0; g < Tout; g++)
      sum[g*W_PSUM +: W_PSUM] = operand[g*W_PSUM +: W_PSUM] + s1_acc[g*W_PSUM +: W_PSUM];
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_en) ram[s1_addr] <= sum;
    rd_data <= ram[addr_in];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld      <= 1'b0;
      s1_fwd      <= 1'b0;
      s2_vld      <= 1'b0;
      o_vld       <= 1'b0;
      o_data_flat <= '0;
      o_row       <= '0;
      o_col       <= '0;
    end else begin
      s1_vld      <= i_vld;
      s1_fwd      <= fwd_hit;
      s1_fwd_data <= sum;
      if (i_vld) begin
        s1_first <= i_first_tile;
        s1_last  <= i_last_tile;
        s1_acc   <= i_acc_flat;
        s1_row   <= i_row;
        s1_col   <= i_col;
        s1_addr  <= addr_in;
      end
      s2_vld <= s1_vld && s1_last;
      if (s1_vld && s1_last) begin
        s2_sum <= sum;
        s2_row <= s1_row;
        s2_col <= s1_col;
      end
      o_vld <= s2_vld;
      if (s2_vld) begin
        o_data_flat <= q_flat;
        o_row       <= s2_row;
        o_col       <= s2_col;
      end
    end
  end

  for (genvar g = 0; g < Tout; g++) begin : g_lane
    psum_postproc #(
      .W_PSUM (W_PSUM),
      .OUT_DW (OUT_DW),
      .W_SHIFT(W_SHIFT)
    ) u_pp (
      .sum  (s2_sum[g*W_PSUM +: W_PSUM]),
      .bias (i_bias_flat[g*W_PSUM +: W_PSUM]),
      .shift(i_shift),
      .relu (i_relu),
      .q    (q_flat[g*OUT_DW +: OUT_DW])
    );
  end

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Scoreboard bench for psum_acc_buffer: directed words, hand-computed expected outputs.
module tb_psum_acc_buffer;

  logic         clk = 1'b0;
  logic         rstn;
  logic [8:0]   i_width;
  logic [4:0]   i_shift;
  logic         i_relu;
  logic [127:0] i_bias_flat;
  logic         i_vld;
  logic [127:0] i_acc_flat;
  logic [8:0]   i_row, i_col;
  logic         i_first_tile, i_last_tile;
  logic         o_vld;
  logic [31:0]  o_data_flat;
  logic [8:0]   o_row, o_col;

  always #5 clk = ~clk;

  psum_acc_buffer u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_width     (i_width),
    .i_shift     (i_shift),
    .i_relu      (i_relu),
    .i_bias_flat (i_bias_flat),
    .i_vld       (i_vld),
    .i_acc_flat  (i_acc_flat),
    .i_row       (i_row),
    .i_col       (i_col),
    .i_first_tile(i_first_tile),
    .i_last_tile (i_last_tile),
    .o_vld       (o_vld),
    .o_data_flat (o_data_flat),
    .o_row       (o_row),
    .o_col       (o_col)
  );

  typedef struct {
    logic [31:0] data;
    logic [8:0]  row;
    logic [8:0]  col;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_vld: got o_vld=1 row %0d col %0d expected no output", o_row, o_col);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", 64'(o_data_flat), 64'(e.data));
        check("row", 64'(o_row), 64'(e.row));
        check("col", 64'(o_col), 64'(e.col));
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [127:0] acc4(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [31:0] out4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic send(input int row, input int col, input logic first, input logic last,
                      input logic [127:0] acc, input logic [31:0] expd, input logic expect_out);
    @(posedge clk);
    #1;
    i_vld        = 1'b1;
    i_row        = 9'(row);
    i_col        = 9'(col);
    i_first_tile = first;
    i_last_tile  = last;
    i_acc_flat   = acc;
    if (last && expect_out) exp_q.push_back('{expd, 9'(row), 9'(col), cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_vld = 1'b0;
    end
  endtask

  task automatic cfg(input logic [127:0] bias, input logic [4:0] shift, input logic relu);
    idle(5);
    i_bias_flat = bias;
    i_shift     = shift;
    i_relu      = relu;
  endtask

  initial begin
    int w;
    rstn = 1'b0; i_width = 9'd16; i_shift = '0; i_relu = 1'b0; i_bias_flat = '0;
    i_vld = 1'b0; i_acc_flat = '0; i_row = '0; i_col = '0;
    i_first_tile = 1'b0; i_last_tile = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_vld", 64'(o_vld), 64'd0);
    check("reset_data", 64'(o_data_flat), 64'd0);
    check("reset_row", 64'(o_row), 64'd0);
    check("reset_col", 64'(o_col), 64'd0);

    // Single tile saturates lane 2; a stored value at the same address survives it.
    cfg('0, 5'd0, 1'b0);
    send(0, 5, 1, 0, acc4(1, 2, 3, 4), '0, 0);
    idle(3);
    send(0, 5, 1, 1, acc4(10, -20, 300, 5), out4(10, -20, 127, 5), 1);
    idle(3);
    send(0, 5, 0, 1, acc4(0, 0, 0, 0), out4(1, 2, 3, 4), 1);

    // Three spaced tiles at addr 18 with bias and shift 2.
    cfg(acc4(6, -3, 0, 1000), 5'd2, 1'b0);
    send(1, 2, 1, 0, acc4(100, 0, 0, 0), '0, 0);
    idle(2);
    send(1, 2, 0, 0, acc4(100, 0, 0, 0), '0, 0);
    idle(2);
    send(1, 2, 0, 1, acc4(100, 0, 0, 0), out4(77, -1, 0, 127), 1);

    // Read-after-write hazards: adjacent, distance two, and a three-deep chain.
    cfg('0, 5'd0, 1'b0);
    send(2, 0, 1, 0, acc4(7, 7, 7, 7), '0, 0);
    send(2, 0, 0, 1, acc4(8, 8, 8, 8), out4(15, 15, 15, 15), 1);
    idle(3);
    send(2, 1, 1, 0, acc4(7, 7, 7, 7), '0, 0);
    send(3, 3, 1, 1, acc4(1, 1, 1, 1), out4(1, 1, 1, 1), 1);
    send(2, 1, 0, 1, acc4(8, 8, 8, 8), out4(15, 15, 15, 15), 1);
    idle(3);
    send(2, 2, 1, 0, acc4(7, -7, 7, 7), '0, 0);
    send(2, 2, 0, 0, acc4(8, -8, 8, 8), '0, 0);
    send(2, 2, 0, 1, acc4(9, -9, 9, 9), out4(24, -24, 24, 24), 1);

    // ReLU, saturation, and rounding shift.
    cfg('0, 5'd0, 1'b1);
    send(3, 0, 1, 1, acc4(-50, 10, -1, 0), out4(0, 10, 0, 0), 1);
    cfg('0, 5'd0, 1'b0);
    send(3, 1, 1, 1, acc4(-300, 200, -128, 127), out4(-128, 127, -128, 127), 1);
    cfg('0, 5'd3, 1'b0);
    send(3, 2, 1, 1, acc4(1000, -1000, 12, 4), out4(125, -125, 2, 1), 1);

    // Reset right after a last-tile word discards it.
    cfg('0, 5'd0, 1'b0);
    send(4, 0, 1, 1, acc4(9, 9, 9, 9), '0, 0);
    @(posedge clk);
    #1 i_vld = 1'b0; rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_vld", 64'(o_vld), 64'd0);
      check("rst_mid_data", 64'(o_data_flat), 64'd0);
      check("rst_mid_row", 64'(o_row), 64'd0);
    end
    send(4, 1, 1, 1, acc4(5, 6, 7, 8), out4(5, 6, 7, 8), 1);

    // Streaming 16x3 frame, two tiles back to back.
    cfg('0, 5'd0, 1'b0);
    for (int p = 0; p < 48; p++)
      send(p / 16, p % 16, 1, 0, acc4(p, p + 1, 2 * p, -p), '0, 0);
    for (int p = 0; p < 48; p++)
      send(p / 16, p % 16, 0, 1, acc4(1, 1, 1, 1), out4(p + 1, p + 2, 2 * p + 1, 1 - p), 1);
    idle(1);

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending outputs expected 0", exp_q.size());
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
